// File: rtl/fft32.sv
// fft32: 32-point radix-2 DIT forward DFT on 8-bit complex samples, Q1.14 twiddles, data carried as Q17.14.
// Latency 1 clk: combinational butterflies feed a single output register; one transform per clock.
// No backpressure; define FFT32_SAT_EN to saturate each output component, otherwise it wraps to 8 bits.
module fft32 (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] Xn_vect_real,
    input  logic [255:0] Xn_vect_imag,
    output logic [255:0] Xk_vect_real,
    output logic [255:0] Xk_vect_imag
);
    localparam int N  = 32;
    localparam int FB = 14;

    typedef logic signed [31:0] samp_t;
    typedef logic signed [47:0] prod_t;
    typedef logic signed [15:0] coef_t;

    localparam samp_t SHALF = 32'sd8192;
    localparam prod_t PHALF = 48'sd8192;

    // cos(m * 11.25 deg) in Q1.14 for the first quadrant; the other twiddles are folded onto it
    function automatic coef_t cos_tab(input logic [3:0] m);
        case (m)
            4'd0:    return 16'sd16384;
            4'd1:    return 16'sd16069;
            4'd2:    return 16'sd15137;
            4'd3:    return 16'sd13623;
            4'd4:    return 16'sd11585;
            4'd5:    return 16'sd9102;
            4'd6:    return 16'sd6270;
            4'd7:    return 16'sd3196;
            default: return 16'sd0;
        endcase
    endfunction

    function automatic logic [4:0] bitrev5(input logic [4:0] v);
        return {v[0], v[1], v[2], v[3], v[4]};
    endfunction

    function automatic logic [7:0] reduce8(input samp_t v);
        samp_t r;
        r = (v + SHALF) >>> FB;
`ifdef FFT32_SAT_EN
        if (r > 32'sd127)
            return 8'h7f;
        else if (r < -32'sd128)
            return 8'h80;
        else
            return 8'(r);
`else
        return 8'(r);
`endif
    endfunction

    logic [255:0] d_real;
    logic [255:0] d_imag;

    always_comb begin : butterflies
        samp_t      cr [N];
        samp_t      ci [N];
        samp_t      nr [N];
        samp_t      ni [N];
        samp_t      br, bi, tr, ti;
        prod_t      pr, pi;
        coef_t      wc, ws;
        logic [4:0] ia, ib, k;
        int         half;

        d_real = '0;
        d_imag = '0;
        br = '0; bi = '0; tr = '0; ti = '0;
        pr = '0; pi = '0; wc = '0; ws = '0;
        ia = '0; ib = '0; k = '0; half = 0;
        for (int n = 0; n < N; n++) begin
            cr[5'(n)] = '0; ci[5'(n)] = '0;
            nr[5'(n)] = '0; ni[5'(n)] = '0;
        end

        for (int n = 0; n < N; n++) begin
            ia = bitrev5(5'(n));
            cr[ia] = samp_t'(signed'(Xn_vect_real[8*n +: 8])) <<< FB;
            ci[ia] = samp_t'(signed'(Xn_vect_imag[8*n +: 8])) <<< FB;
        end

        for (int s = 0; s < 5; s++) begin
            half = 1 << s;
            for (int i = 0; i < N; i++) begin
                if ((i & half) == 0) begin
                    ia = 5'(i);
                    ib = 5'(i + half);
                    k  = 5'((i & (half - 1)) << (4 - s));
                    br = cr[ib];
                    bi = ci[ib];
                    if (k == 5'd0) begin
                        tr = br;
                        ti = bi;
                    end else if (k == 5'd8) begin
                        // multiply by -j: swap and negate
                        tr = bi;
                        ti = -br;
                    end else begin
                        wc = (k <= 5'd8) ? cos_tab(k[3:0]) : -cos_tab(4'(5'd16 - k));
                        ws = (k <= 5'd8) ? cos_tab(4'(5'd8 - k)) : cos_tab(4'(k - 5'd8));
                        pr = prod_t'(br) * prod_t'(wc) + prod_t'(bi) * prod_t'(ws);
                        pi = prod_t'(bi) * prod_t'(wc) - prod_t'(br) * prod_t'(ws);
                        tr = samp_t'((pr + PHALF) >>> FB);
                        ti = samp_t'((pi + PHALF) >>> FB);
                    end
                    nr[ia] = cr[ia] + tr;
                    ni[ia] = ci[ia] + ti;
                    nr[ib] = cr[ia] - tr;
                    ni[ib] = ci[ia] - ti;
                end
            end
            cr = nr;
            ci = ni;
        end

        for (int n = 0; n < N; n++) begin
            d_real[8*n +: 8] = reduce8(cr[5'(n)]);
            d_imag[8*n +: 8] = reduce8(ci[5'(n)]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Xk_vect_real <= '0;
            Xk_vect_imag <= '0;
        end else begin
            Xk_vect_real <= d_real;
            Xk_vect_imag <= d_imag;
        end
    end

endmodule

// File: tb/tb_fft32.sv
// tb_fft32: drives directed and random vectors into fft32 and compares every bin against a direct DFT.
// Expected values follow FFT32_SAT_EN the same way the design does (saturate vs. 8-bit wrap).
module tb_fft32;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] Xn_vect_real;
    logic [255:0] Xn_vect_imag;
    logic [255:0] Xk_vect_real;
    logic [255:0] Xk_vect_imag;

    always #5 clk = ~clk;

    fft32 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Xn_vect_real (Xn_vect_real),
        .Xn_vect_imag (Xn_vect_imag),
        .Xk_vect_real (Xk_vect_real),
        .Xk_vect_imag (Xk_vect_imag)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int in_re  [32];
    int in_im  [32];
    int exp_re [32];
    int exp_im [32];

    // differences are taken modulo 256 so a wrapped output one LSB across the sign boundary still matches
    task automatic check(input string tag, input int obs, input int exp_v, input int tol = 0);
        logic signed [7:0] d8;
        int d;
        n_tests++;
        d8 = 8'(obs - exp_v);
        d  = int'(d8);
        if (d > tol || d < -tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp_v, tol);
        end
    endtask

    function automatic int reduce(input int r);
`ifdef FFT32_SAT_EN
        if (r > 127) return 127;
        if (r < -128) return -128;
        return r;
`else
        logic signed [7:0] w;
        w = 8'(r);
        return int'(w);
`endif
    endfunction

    function automatic int out_re(input int k);
        logic signed [7:0] v;
        v = Xk_vect_real[8*k +: 8];
        return int'(v);
    endfunction

    function automatic int out_im(input int k);
        logic signed [7:0] v;
        v = Xk_vect_imag[8*k +: 8];
        return int'(v);
    endfunction

    task automatic clear_in();
        for (int n = 0; n < 32; n++) begin
            in_re[n] = 0;
            in_im[n] = 0;
        end
    endtask

    task automatic drive();
        for (int n = 0; n < 32; n++) begin
            Xn_vect_real[8*n +: 8] = 8'(in_re[n]);
            Xn_vect_imag[8*n +: 8] = 8'(in_im[n]);
        end
    endtask

    // direct O(N^2) DFT in double precision, rounded to nearest then reduced to 8 bits
    task automatic model();
        real sr, si, th;
        for (int k = 0; k < 32; k++) begin
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < 32; n++) begin
                th = 2.0 * 3.14159265358979323846 * real'(n * k) / 32.0;
                sr = sr + real'(in_re[n]) * $cos(th) + real'(in_im[n]) * $sin(th);
                si = si + real'(in_im[n]) * $cos(th) - real'(in_re[n]) * $sin(th);
            end
            exp_re[k] = reduce($rtoi($floor(sr + 0.5)));
            exp_im[k] = reduce($rtoi($floor(si + 0.5)));
        end
    endtask

    task automatic check_all(input string tag, input int tol);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("%s re[%0d]", tag, k), out_re(k), exp_re[k], tol);
            check($sformatf("%s im[%0d]", tag, k), out_im(k), exp_im[k], tol);
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("%s re[%0d]", tag, k), out_re(k), 0);
            check($sformatf("%s im[%0d]", tag, k), out_im(k), 0);
        end
    endtask

    initial begin
        int ovf_exp;
        rst_n = 1'b0;
        for (int n = 0; n < 32; n++) begin
            in_re[n] = $urandom_range(0, 255) - 128;
            in_im[n] = $urandom_range(0, 255) - 128;
        end
        drive();
        #2;
        check_zero("reset");

        @(negedge clk);
        rst_n = 1'b1;

        // impulse, then DC on the very next cycle
        clear_in();
        in_re[0] = 16;
        drive();
        model();
        @(posedge clk);
        #1;
        check_all("imp model", 1);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("imp re[%0d]", k), out_re(k), 16);
            check($sformatf("imp im[%0d]", k), out_im(k), 0);
        end
        for (int n = 0; n < 32; n++) in_re[n] = 1;
        drive();
        #3;
        check("hold re[0]", out_re(0), 16);
        check("hold re[5]", out_re(5), 16);
        model();
        @(posedge clk);
        #1;
        check_all("dc model", 1);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("dc re[%0d]", k), out_re(k), (k == 0) ? 32 : 0);
            check($sformatf("dc im[%0d]", k), out_im(k), 0);
        end

        // single tone at sample 1
        @(negedge clk);
        clear_in();
        in_re[1] = 16;
        drive();
        model();
        @(posedge clk);
        #1;
        check_all("tone model", 1);
        check("tone re[0]", out_re(0), 16);
        check("tone im[0]", out_im(0), 0);
        check("tone re[8]", out_re(8), 0);
        check("tone im[8]", out_im(8), -16);
        check("tone re[16]", out_re(16), -16);
        check("tone im[16]", out_im(16), 0);
        check("tone re[24]", out_re(24), 0);
        check("tone im[24]", out_im(24), 16);

        // DC overflow in both directions
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            clear_in();
            for (int n = 0; n < 32; n++) in_re[n] = (pass == 0) ? 16 : -16;
            drive();
`ifdef FFT32_SAT_EN
            ovf_exp = (pass == 0) ? 127 : -128;
`else
            ovf_exp = 0;
`endif
            @(posedge clk);
            #1;
            check($sformatf("ovf%0d re[0]", pass), out_re(0), ovf_exp);
            for (int k = 1; k < 32; k++)
                check($sformatf("ovf%0d re[%0d]", pass, k), out_re(k), 0);
            for (int k = 0; k < 32; k++)
                check($sformatf("ovf%0d im[%0d]", pass, k), out_im(k), 0);
        end

        // reset mid-stream: clears between edges and holds zero across an edge
        @(negedge clk);
        for (int n = 0; n < 32; n++) begin
            in_re[n] = $urandom_range(0, 32) - 16;
            in_im[n] = $urandom_range(0, 32) - 16;
        end
        drive();
        model();
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        @(posedge clk);
        #1;
        check_zero("rsthold");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("postrst", 1);

        // random vectors against the double-precision reference
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            for (int n = 0; n < 32; n++) begin
                in_re[n] = $urandom_range(0, 32) - 16;
                in_im[n] = $urandom_range(0, 32) - 16;
            end
            drive();
            model();
            @(posedge clk);
            #1;
            check_all($sformatf("rnd%0d", v), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft32.md
FFT32 -- requirements
Module: fft32

Interface
REQ-001 The module SHALL have no parameters; point count N = 32 and sample width W = 8 are fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Xn_vect_real  input  256  32 signed 8-bit two's-complement real input samples; sample n occupies bits [8n+7:8n].
REQ-005 Xn_vect_imag  input  256  32 signed 8-bit imaginary input samples, same packing as Xn_vect_real.
REQ-006 Xk_vect_real  output  256  32 signed 8-bit real output bins; bin k occupies bits [8k+7:8k], natural (not bit-reversed) order.
REQ-007 Xk_vect_imag  output  256  32 signed 8-bit imaginary output bins, same packing as Xk_vect_real.

Function
REQ-008 The module SHALL compute the unscaled forward DFT: X[k] = sum over n=0..31 of x[n]·e^(-j2πnk/32), with no 1/N normalisation.
REQ-009 The transform SHALL be a radix-2 Cooley-Tukey structure: 5 butterfly stages, input bit-reversal, combinational between the input sample and the output register.
REQ-010 Twiddle factors SHALL be constants in signed Q1.14 (scale 16384), rounded to nearest.
REQ-011 Internal adders SHALL be wide enough that no intermediate overflow occurs for any 8-bit input (minimum 16 integer bits plus the twiddle fraction).
REQ-012 Each twiddle product SHALL be rounded to nearest (add 2^13, arithmetic shift right 14) before the next stage.
REQ-013 Trivial twiddles (W^0, W^8) SHALL be implemented as pass-through or negate/swap without multiplication.
REQ-014 Each final bin component SHALL be reduced to 8 bits per the Configuration section.
REQ-015 Xn_vect_real and Xn_vect_imag SHALL be sampled at every rising clk edge; results SHALL appear on the outputs after exactly 1 clock edge (latency 1, throughput 1 transform per clock).
REQ-016 There SHALL be no handshake; a new input vector each cycle yields a new output vector each cycle.
REQ-017 Real and imaginary outputs SHALL always update on the same edge.

Reset
REQ-018 While rst_n = 0, Xk_vect_real and Xk_vect_imag SHALL be all zeros, asynchronously, independent of clk.
REQ-019 Reset asserted mid-stream SHALL discard the in-flight result.
REQ-020 The first clk rising edge after rst_n deasserts SHALL load the transform of the inputs present at that edge.

Configuration
REQ-021 Macro FFT32_SAT_EN defined: each output component SHALL saturate to [-128, 127]: values > 127 give 0x7F, values < -128 give 0x80.
REQ-022 Macro FFT32_SAT_EN undefined: each output component SHALL be the low 8 bits of the rounded result (two's-complement wrap).

Verification
REQ-023 Impulse: real sample 0 = 0x10, all other inputs 0 -> every bin real = 0x10, imag = 0x00.
REQ-024 DC: all real = 0x01, imag = 0 -> bin 0 real = 0x20, all other components 0x00.
REQ-025 Tone: real sample 1 = 0x10, all else 0:
  - bin 8 -> (0x00, 0xF0)
  - bin 0 -> (0x10, 0x00)
  - bin 16 -> (0xF0, 0x00)
  - bin 24 -> (0x00, 0x10)
REQ-026 Overflow: all real = 0x10 -> bin 0 real = 0x7F with FFT32_SAT_EN (0x00 without); all real = 0xF0 -> 0x80 with FFT32_SAT_EN (0x00 without); other bins 0.
REQ-027 Latency/reset:
  - drive the impulse vector, then the DC vector, on consecutive cycles -> outputs follow exactly 1 edge later each;
  - assert rst_n = 0 between edges -> outputs 0 immediately;
  - deassert rst_n -> first edge restores the transform.
REQ-028 Random: 10 vectors with samples uniform in [-16, 16] -> each component within ±1 LSB of a double-precision reference DFT, saturated per REQ-021.
